// File: rtl/loop_stack_ctl.sv
// Clocked loop-address stack with a forward bracket-skip engine for the brainfuck computer.
// Define LOOP_STACK_STICKY_ERR_EN to make overflow/underflow sticky until rst.
module loop_stack_ctl #(
  parameter int AW       = 10,
  parameter int DEPTH    = 32,
  parameter int SKIP_MAX = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                addr_in,
  output logic [AW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         skip_start,
  input  logic                         skip_open,
  input  logic                         skip_close,
  output logic                         skipping,
  output logic                         skip_done
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(SKIP_MAX + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SKIP
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            skip_done_q, skip_done_d;
  logic [AW-1:0]   entry_q [DEPTH];

  logic            ovf_ev, unf_ev;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   top_idx;

  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(DEPTH));
  assign top_idx = IW'(depth_q - DW'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    depth_d     = depth_q;
    count_d     = count_q;
    skip_done_d = 1'b0;
    ovf_ev      = 1'b0;
    unf_ev      = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = IW'(depth_q);

    case (state_q)
      ST_IDLE: begin
        if (skip_start) begin
          state_d = ST_SKIP;
          count_d = CW'(1);
        end else if (push && pop && !empty) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else if (push) begin
          if (full) begin
            ovf_ev = 1'b1;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + DW'(1);
          end
        end else if (pop) begin
          if (empty) unf_ev = 1'b1;
          else       depth_d = depth_q - DW'(1);
        end
      end

      ST_SKIP: begin
        // Stack requests are deliberately dropped here: the stack stays frozen while skipping.
        if (skip_open && !skip_close) begin
          if (count_q == CW'(SKIP_MAX)) ovf_ev  = 1'b1;
          else                          count_d = count_q + CW'(1);
        end else if (skip_close && !skip_open) begin
          if (count_q == CW'(1)) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            skip_done_d = 1'b1;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
    endcase

`ifdef LOOP_STACK_STICKY_ERR_EN
    overflow_d  = overflow_q  | ovf_ev;
    underflow_d = underflow_q | unf_ev;
`else
    overflow_d  = ovf_ev;
    underflow_d = unf_ev;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      skip_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      skip_done_q <= skip_done_d;
    end
  end

  // NOTE: storage is not reset; depth_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) entry_q[wr_idx] <= addr_in;
  end

  assign top       = empty ? '0 : entry_q[top_idx];
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign skipping  = (state_q == ST_SKIP);
  assign skip_done = skip_done_q;

endmodule

// File: tb/tb_loop_stack_ctl.sv
// Directed self-checking bench for loop_stack_ctl (default parameters).
module tb_loop_stack_ctl;

  localparam int AW    = 10;
  localparam int DEPTH = 32;

`ifdef LOOP_STACK_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, push, pop, skip_start, skip_open, skip_close;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] top;
  logic [5:0]    depth;
  logic          empty, full, overflow, underflow, skipping, skip_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  loop_stack_ctl #(.AW(AW), .DEPTH(DEPTH), .SKIP_MAX(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .addr_in    (addr_in),
    .top        (top),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow),
    .skip_start (skip_start),
    .skip_open  (skip_open),
    .skip_close (skip_close),
    .skipping   (skipping),
    .skip_done  (skip_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; push = 1'b0; pop = 1'b0; addr_in = '0;
    skip_start = 1'b0; skip_open = 1'b0; skip_close = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [AW-1:0] a);
    clr(); push = 1'b1; addr_in = a; tick(); clr();
  endtask

  task automatic do_pop();
    clr(); pop = 1'b1; tick(); clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick();
    clr();
    check("rst_depth", depth, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_skipping", skipping, 0);
    check("rst_skip_done", skip_done, 0);
    check("rst_top", top, 0);

    // Basic pushes
    do_push(10'h010);
    check("push1_top", top, 10'h010);
    check("push1_depth", depth, 1);
    do_push(10'h020);
    do_push(10'h030);
    check("push3_depth", depth, 3);
    check("push3_top", top, 10'h030);
    check("push3_empty", empty, 0);

    // Replace top
    push = 1'b1; pop = 1'b1; addr_in = 10'h3FF; tick(); clr();
    check("repl_depth", depth, 3);
    check("repl_top", top, 10'h3FF);
    check("repl_ovf", overflow, 0);
    do_pop();
    check("pop1_top", top, 10'h020);
    check("pop1_depth", depth, 2);
    do_pop();
    do_pop();
    check("pop3_depth", depth, 0);
    check("pop3_top", top, 0);
    check("pop3_empty", empty, 1);

    // Fill to DEPTH, then overflow
    for (int i = 1; i <= DEPTH; i++) do_push(AW'(i));
    check("fill_full", full, 1);
    check("fill_depth", depth, DEPTH);
    check("fill_top", top, DEPTH);
    check("fill_ovf", overflow, 0);
    do_push(10'd33);
    check("ovf_pulse", overflow, 1);
    check("ovf_top", top, DEPTH);
    check("ovf_depth", depth, DEPTH);
    tick();
    check("ovf_after", overflow, STICKY);
    push = 1'b1; pop = 1'b1; addr_in = 10'h2AA; tick(); clr();
    check("full_repl_top", top, 10'h2AA);
    check("full_repl_depth", depth, DEPTH);
    check("full_repl_ovf", overflow, STICKY);

    for (int i = 0; i < DEPTH; i++) do_pop();
    check("drain_depth", depth, 0);
    check("drain_empty", empty, 1);
    check("drain_unf", underflow, 0);
    do_pop();
    check("unf_pulse", underflow, 1);
    check("unf_depth", depth, 0);
    tick();
    check("unf_after", underflow, STICKY);

    // push+pop on empty behaves as push
    push = 1'b1; pop = 1'b1; addr_in = 10'h0AB; tick(); clr();
    check("pp_empty_depth", depth, 1);
    check("pp_empty_top", top, 10'h0AB);
    check("pp_empty_unf", underflow, STICKY);
    do_pop();

    // Skip: start, open x2, close x3
    skip_start = 1'b1; tick(); clr();
    check("sk_start", skipping, 1);
    check("sk_start_done", skip_done, 0);
    skip_open = 1'b1; tick(); check("sk_o1", skipping, 1);
    tick(); check("sk_o2", skipping, 1);
    clr(); skip_close = 1'b1; tick(); check("sk_c1", skipping, 1);
    tick(); check("sk_c2", skipping, 1);
    check("sk_c2_done", skip_done, 0);
    tick(); clr();
    check("sk_c3_skipping", skipping, 0);
    check("sk_c3_done", skip_done, 1);
    tick();
    check("sk_done_pulse", skip_done, 0);

    // Stack frozen during skip; skip_start beats push
    do_push(10'h111);
    do_push(10'h122);
    skip_start = 1'b1; push = 1'b1; addr_in = 10'h199; tick(); clr();
    check("ss_push_skip", skipping, 1);
    check("ss_push_depth", depth, 2);
    check("ss_push_top", top, 10'h122);
    do_push(10'h155);
    check("frz_push_depth", depth, 2);
    check("frz_push_top", top, 10'h122);
    check("frz_push_ovf", overflow, STICKY);
    do_pop();
    check("frz_pop_depth", depth, 2);
    check("frz_pop_unf", underflow, STICKY);
    skip_open = 1'b1; skip_close = 1'b1; tick(); clr();
    check("oc_both", skipping, 1);
    skip_open = 1'b1; tick(); clr();
    skip_start = 1'b1; tick(); clr();
    skip_close = 1'b1; tick(); clr();
    check("ss_ignored", skipping, 1);
    skip_close = 1'b1; tick(); clr();
    check("nest_end_skip", skipping, 0);
    check("nest_end_done", skip_done, 1);

    // Skip-depth saturation at SKIP_MAX
    skip_start = 1'b1; tick(); clr();
    skip_open = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("sat_pre_ovf", overflow, STICKY);
    tick(); clr();
    check("sat_ovf", overflow, 1);
    skip_close = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("sat_hold_skip", skipping, 1);
    tick(); clr();
    check("sat_end_skip", skipping, 0);
    check("sat_end_done", skip_done, 1);

    // Reset mid-skip with depth 5
    do_push(10'h133);
    do_push(10'h144);
    do_push(10'h155);
    check("pre_rst_depth", depth, 5);
    skip_start = 1'b1; tick(); clr();
    check("pre_rst_skip", skipping, 1);
    skip_open = 1'b1; rst = 1'b1; tick(); clr();
    check("mid_rst_skip", skipping, 0);
    check("mid_rst_depth", depth, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_top", top, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_unf", underflow, 0);
    skip_close = 1'b1; tick(); clr();
    check("post_rst_done", skip_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/loop_stack_ctl.md
Name: loop_stack_ctl

Overview:
Parametrised, clocked successor to the combinational loop stack in the brainfuck computer. Holds return addresses for nested '[' ... ']' loops with registered push/pop/replace, occupancy and error flags. Adds a bracket-skip engine that tracks nesting depth while the fetch unit scans forward past a loop whose cell is zero. Sits between instruction decode and the program counter mux.

Parameters:
AW, 10, address width of stored program addresses
DEPTH, 32, number of stack entries (any value >= 2)
SKIP_MAX, 255, maximum nesting depth counted during skip

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
push  in  1  '[' entered with nonzero cell: store addr_in
pop  in  1  ']' with zero cell: discard top entry
addr_in  in  AW  address pushed (address of the '[')
top  out  AW  current top entry; 0 when empty
depth  out  $clog2(DEPTH+1)  number of valid entries
empty  out  1  depth == 0
full  out  1  depth == DEPTH
overflow  out  1  push rejected because stack full
underflow  out  1  pop rejected because stack empty
skip_start  in  1  '[' decoded with zero cell: begin forward skip
skip_open  in  1  '[' fetched while skipping
skip_close  in  1  ']' fetched while skipping
skipping  out  1  skip engine active
skip_done  out  1  one-cycle pulse: matching ']' found

Behaviour:
- Reset: depth=0, empty=1, full=0, overflow=0, underflow=0, skipping=0, skip_done=0, top=0, skip count=0. Storage contents need not be cleared. Reset takes priority over every other input, including mid-skip.
- top is a combinational read of entry[depth-1] from the registered array, forced to 0 when empty. Push/pop take effect at the clock edge, and top/depth reflect them in the following cycle (1-cycle latency).
- Stack FSM state IDLE, with push/pop honoured:
  - push only, not full: entry[depth]<=addr_in, depth+1.
  - push only, full: storage unchanged, overflow=1.
  - pop only, not empty: depth-1.
  - pop only, empty: no change, underflow=1.
  - push and pop together, not empty: replace top with addr_in, depth unchanged. Never flags overflow, even when full.
  - push and pop together, empty: treated as push only.
- overflow/underflow are single-cycle pulses by default (see Optional Feature).
- Skip FSM states: IDLE, SKIP.
  - IDLE, skip_start=1: go to SKIP, count<=1, skipping=1 next cycle. skip_start is ignored while in SKIP.
  - SKIP, skip_open only: count+1. At SKIP_MAX, count holds and overflow=1.
  - SKIP, skip_close only, count>1: count-1.
  - SKIP, skip_close only, count==1: go to IDLE, count<=0, skip_done=1 for one cycle, skipping=0 from the next cycle.
  - SKIP, skip_open and skip_close together: count unchanged.
- While in SKIP, push and pop are ignored, the stack is frozen and no flags are raised by them.
- skip_start together with push or pop in IDLE: skip_start wins and the stack operation is ignored.

Optional Feature:
Macro LOOP_STACK_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Each sets on its condition and clears only on rst.
- Undefined: each is a single-cycle pulse, asserted in the cycle after the offending request.

Test Plan:
- rst, then push addr 0x010, 0x020, 0x030 on consecutive cycles -> depth=3, top=0x030, empty=0.
- From depth=3, push and pop together with addr_in=0x3FF -> depth=3, top=0x3FF. Then pop x3 -> depth=0, top=0, empty=1.
- DEPTH=32: push 33 times -> full=1 at depth 32, overflow pulse on the 33rd, top still the 32nd value. Pop on empty -> underflow pulse, depth stays 0.
- skip_start, then skip_open x2, skip_close x3 -> skipping high for 5 cycles, skip_done pulses on the 3rd close, count returns to 0.
- During SKIP, push addr 0x155 -> depth and top unchanged. Simultaneous skip_open and skip_close -> count unchanged.
- rst asserted mid-skip with depth=5 -> next cycle skipping=0, depth=0, empty=1. With LOOP_STACK_STICKY_ERR_EN, an earlier overflow stays high until this rst, then reads 0.
